// File: rtl/wb_hazard_scoreboard.sv
// wb_hazard_scoreboard: stall and forwarding controller for a 5-stage MIPS pipeline.
//
// The block tracks the in-flight writers in E, M and W. For each one it keeps the
// destination register and the number of cycles until that result can be forwarded
// (tnew). It compares these against the sources of the D-stage instruction, using the
// cycle in which each source is first needed (tuse). From that it produces the D-stage
// stall and the forwarding selects for the D and E stages. All outputs are
// combinational. Reset forces every output to 0.
//
// Ports:
//   clk                  core clock
//   reset                synchronous, active-high reset
//   d_rs, d_rt           D-stage source register indices
//   d_tuse_rs/rt         cycles until each source is consumed (TUSE_NONE = not read)
//   d_we, d_dst, d_tnew  D-stage writer info (d_tnew counted from entry into E)
//   stall                freeze PC and F/D, insert a bubble into E
//   fwd_d_rs/rt          D-stage operand source: 0 regfile, 1 E, 2 M, 3 W
//   fwd_e_rs/rt          E-stage operand source: 0 pipeline value, 2 M, 3 W

module wb_hazard_scoreboard #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned T_W       = 2,
  parameter int unsigned TUSE_NONE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [T_W-1:0]   d_tuse_rs,
  input  logic [T_W-1:0]   d_tuse_rt,
  input  logic             d_we,
  input  logic [REG_W-1:0] d_dst,
  input  logic [T_W-1:0]   d_tnew,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt
);

  localparam logic [T_W-1:0] TuseNone = T_W'(TUSE_NONE);

  localparam logic [1:0] SrcNone = 2'd0;
  localparam logic [1:0] SrcE    = 2'd1;
  localparam logic [1:0] SrcM    = 2'd2;
  localparam logic [1:0] SrcW    = 2'd3;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [REG_W-1:0] dst;
    logic [T_W-1:0]   tnew;
  } entry_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] fwd;
  } d_res_t;

  entry_t           e_q, m_q, w_q;
  logic [REG_W-1:0] e_rs_q, e_rt_q;

  d_res_t     rs_res, rt_res;
  logic [1:0] e_rs_sel, e_rt_sel;

  // True when entry x holds a real register write to idx. $0 never counts.
  function automatic logic writes(input entry_t x, input logic [REG_W-1:0] idx);
    return x.valid && x.we && (x.dst != '0) && (x.dst == idx);
  endfunction

  // One stage of aging: tnew counts down and saturates at 0.
  function automatic entry_t age(input entry_t x);
    entry_t r;
    r = x;
    if (x.tnew != '0) r.tnew = x.tnew - T_W'(1);
    return r;
  endfunction

  // D-stage lookup. The youngest matching writer is the only one considered, even
  // when its result is not ready yet. An older, ready value would be stale.
  function automatic d_res_t d_lookup(input logic [REG_W-1:0] idx,
                                      input logic [T_W-1:0]   tuse,
                                      input entry_t           e,
                                      input entry_t           m,
                                      input entry_t           w);
    d_res_t     r;
    entry_t     hit;
    logic [1:0] code;
    logic       found;
    r     = '0;
    hit   = '0;
    code  = SrcNone;
    found = 1'b0;
    if ((tuse != TuseNone) && (idx != '0)) begin
      if (writes(e, idx)) begin
        hit   = e;
        code  = SrcE;
        found = 1'b1;
      end else if (writes(m, idx)) begin
        hit   = m;
        code  = SrcM;
        found = 1'b1;
      end else if (writes(w, idx)) begin
        hit   = w;
        code  = SrcW;
        found = 1'b1;
      end
    end
    if (found) begin
      r.stall = (hit.tnew > tuse);
      r.fwd   = (hit.tnew == '0) ? code : SrcNone;
    end
    return r;
  endfunction

  // E-stage lookup. A not-yet-ready M writer blocks W. D stalls before this can
  // happen legally, so the pipeline value is the safe choice.
  function automatic logic [1:0] e_lookup(input logic [REG_W-1:0] idx,
                                          input entry_t           m,
                                          input entry_t           w);
    logic [1:0] sel;
    sel = SrcNone;
    if (idx != '0) begin
      if (writes(m, idx)) begin
        sel = (m.tnew == '0) ? SrcM : SrcNone;
      end else if (writes(w, idx)) begin
        sel = (w.tnew == '0) ? SrcW : SrcNone;
      end
    end
    return sel;
  endfunction

  always_comb begin
    rs_res   = d_lookup(d_rs, d_tuse_rs, e_q, m_q, w_q);
    rt_res   = d_lookup(d_rt, d_tuse_rt, e_q, m_q, w_q);
    e_rs_sel = e_lookup(e_rs_q, m_q, w_q);
    e_rt_sel = e_lookup(e_rt_q, m_q, w_q);

    // Reset overrides outputs in the same cycle, before the cleared state is visible.
    stall    = 1'b0;
    fwd_d_rs = SrcNone;
    fwd_d_rt = SrcNone;
    fwd_e_rs = SrcNone;
    fwd_e_rt = SrcNone;
    if (!reset) begin
      stall    = rs_res.stall || rt_res.stall;
      fwd_d_rs = rs_res.fwd;
      fwd_d_rt = rt_res.fwd;
      fwd_e_rs = e_rs_sel;
      fwd_e_rt = e_rt_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      e_rs_q <= '0;
      e_rt_q <= '0;
    end else begin
      w_q <= age(m_q);
      m_q <= age(e_q);
      if (stall) begin
        // Bubble: invalid, and no source indices, so it never forwards.
        e_q    <= '0;
        e_rs_q <= '0;
        e_rt_q <= '0;
      end else begin
        e_q.valid <= 1'b1;
        e_q.we    <= d_we && (d_dst != '0);
        e_q.dst   <= d_dst;
        e_q.tnew  <= d_tnew;
        e_rs_q    <= d_rs;
        e_rt_q    <= d_rt;
      end
    end
  end

endmodule

// File: tb/tb_wb_hazard_scoreboard.sv
// Bench for wb_hazard_scoreboard.
//
// Each table row is one D-stage cycle. It holds the D inputs, the reset level, and
// the outputs expected while that row is presented. Expected outputs are queued when
// the row is driven. They are popped and compared once the combinational outputs
// have settled, before the next rising edge. When a row stalls, the next row repeats
// the same D instruction, the way a held F/D register would.

module tb_wb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_we;
  logic       stall;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  wb_hazard_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_we      (d_we),
    .d_dst     (d_dst),
    .d_tnew    (d_tnew),
    .stall     (stall),
    .fwd_d_rs  (fwd_d_rs),
    .fwd_d_rt  (fwd_d_rt),
    .fwd_e_rs  (fwd_e_rs),
    .fwd_e_rt  (fwd_e_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic [1:0] fdrs, fdrt, fers, fert;
  } exp_t;

  typedef struct {
    bit         chk;
    logic       rst;
    logic [4:0] rs, rt, dst;
    logic [1:0] trs, trt, tnew;
    logic       we;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic v(input int rst, input int rs, input int rt, input int trs, input int trt,
                   input int we, input int dst, input int tnew, input int st, input int fdrs,
                   input int fdrt, input int fers, input int fert, input int chk);
    vec_t r;
    r.chk    = (chk != 0);
    r.rst    = rst[0];
    r.rs     = rs[4:0];
    r.rt     = rt[4:0];
    r.trs    = trs[1:0];
    r.trt    = trt[1:0];
    r.we     = we[0];
    r.dst    = dst[4:0];
    r.tnew   = tnew[1:0];
    r.e.stall = st[0];
    r.e.fdrs = fdrs[1:0];
    r.e.fdrt = fdrt[1:0];
    r.e.fers = fers[1:0];
    r.e.fert = fert[1:0];
    tbl.push_back(r);
  endtask

  // D-stage nop: reads nothing, writes nothing.
  task automatic nop(input int fers, input int fert);
    v(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, fers, fert, 1);
  endtask

  task automatic check(input string name, input int step, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    end
  endtask

  initial begin
    exp_t got;
    reset = 1'b1;
    d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_we = 1'b0; d_dst = '0; d_tnew = '0;

    //   rst rs rt trs trt we dst tnew | st fdrs fdrt fers fert chk
    v(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);         // 0: reset, outputs quiet
    nop(0, 0);                                            // 1
    // ALU writer $3 then beq $3: 1-cycle stall, then forward from M
    v(0, 1, 2, 1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1);          // 2
    v(0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);          // 3
    v(0, 3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1);          // 4
    nop(3, 0);                                            // 5: beq in E, $3 in W
    nop(0, 0);                                            // 6
    // lw $5 then addu reading $5 through rt: 1-cycle stall, then E forwards from W
    v(0, 29, 5, 1, 3, 1, 5, 2, 0, 0, 0, 0, 0, 1);         // 7
    v(0, 4, 5, 1, 1, 1, 6, 1, 1, 0, 0, 0, 0, 1);          // 8
    v(0, 4, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 1);          // 9: M tnew 1, no fwd yet
    nop(0, 3);                                            // 10
    nop(0, 0); nop(0, 0);                                 // 11-12
    // jal then jr $31: no stall, forward from E
    v(0, 0, 0, 3, 3, 1, 31, 0, 0, 0, 0, 0, 0, 1);         // 13
    v(0, 31, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1);         // 14
    nop(2, 0);                                            // 15
    nop(0, 0); nop(0, 0);                                 // 16-17
    // Two writers of $7, in M and W: the younger one (M) wins
    v(0, 0, 0, 1, 3, 1, 7, 1, 0, 0, 0, 0, 0, 1);          // 18
    v(0, 0, 0, 1, 3, 1, 7, 1, 0, 0, 0, 0, 0, 1);          // 19
    nop(0, 0);                                            // 20
    v(0, 7, 0, 1, 3, 1, 0, 1, 0, 2, 0, 0, 0, 1);          // 21: also writes $0
    nop(3, 0);                                            // 22
    nop(0, 0); nop(0, 0);                                 // 23-24
    // $7 in W, $0 writer in M: the $0 writer is transparent
    v(0, 0, 0, 1, 3, 1, 7, 1, 0, 0, 0, 0, 0, 1);          // 25
    v(0, 0, 0, 1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 1);          // 26
    nop(0, 0);                                            // 27
    v(0, 0, 7, 3, 1, 0, 0, 0, 0, 0, 3, 0, 0, 1);          // 28
    nop(0, 0);                                            // 29: W is the $0 writer
    nop(0, 0);                                            // 30
    // Writer to $0 alone: never a hazard
    v(0, 0, 0, 1, 3, 1, 0, 2, 0, 0, 0, 0, 0, 1);          // 31
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);          // 32
    nop(0, 0); nop(0, 0); nop(0, 0);                      // 33-35
    // lw $9 in E; D has both sources unused: no stall, no forward
    v(0, 29, 9, 1, 3, 1, 9, 2, 0, 0, 0, 0, 0, 1);         // 36
    v(0, 9, 9, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);          // 37
    nop(0, 0);                                            // 38: M tnew 1 blocks E fwd
    nop(0, 0); nop(0, 0);                                 // 39-40
    // lw $4 then beq $4, reset asserted in the 2nd stall cycle
    v(0, 29, 4, 1, 3, 1, 4, 2, 0, 0, 0, 0, 0, 1);         // 41
    v(0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);          // 42
    v(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);          // 43: reset cycle
    v(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);          // 44: all entries cleared
    nop(0, 0); nop(0, 0); nop(0, 0);                      // 45-47
    // lw $4 then beq $4 without reset: 2-cycle stall, then forward from W
    v(0, 29, 4, 1, 3, 1, 4, 2, 0, 0, 0, 0, 0, 1);         // 48
    v(0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);          // 49
    v(0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);          // 50
    v(0, 4, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1);          // 51
    nop(0, 0);                                            // 52

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset     = tbl[i].rst;
      d_rs      = tbl[i].rs;
      d_rt      = tbl[i].rt;
      d_tuse_rs = tbl[i].trs;
      d_tuse_rt = tbl[i].trt;
      d_we      = tbl[i].we;
      d_dst     = tbl[i].dst;
      d_tnew    = tbl[i].tnew;
      if (tbl[i].chk) exp_q.push_back(tbl[i].e);
      #2;
      if (tbl[i].chk) begin
        got = exp_q.pop_front();
        check("stall", i, int'(stall), int'(got.stall));
        check("fwd_d_rs", i, int'(fwd_d_rs), int'(got.fdrs));
        check("fwd_d_rt", i, int'(fwd_d_rt), int'(got.fdrt));
        check("fwd_e_rs", i, int'(fwd_e_rs), int'(got.fers));
        check("fwd_e_rt", i, int'(fwd_e_rt), int'(got.fert));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_hazard_scoreboard.md
Name: wb_hazard_scoreboard

Overview:
- Pipeline hazard and forwarding controller for the 5-stage MIPS core. It is the consumer side of the write-back control produced by the per-stage decoders.
- Tracks every in-flight writer in E, M and W: write enable, destination register and remaining cycles until its result exists (Tnew).
- Compares these against the D-stage instruction's source registers and their need-time (Tuse) to generate the D-stage stall and the D/E forwarding selects.
- Sits between the D-stage decoder and the datapath forwarding muxes.

Parameters:
- REG_W, 5, register-index width
- T_W, 2, width of the Tnew/Tuse fields
- TUSE_NONE, 3, Tuse value meaning "operand not read"

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- d_rs  input  REG_W  D-stage rs index
- d_rt  input  REG_W  D-stage rt index
- d_tuse_rs  input  T_W  cycles until rs is consumed (0 = branch/jr, 1 = ALU, 2 = store data, 3 = unused)
- d_tuse_rt  input  T_W  same for rt
- d_we  input  1  D-stage instruction writes a register
- d_dst  input  REG_W  D-stage destination index (already resolved: rd/rt/31)
- d_tnew  input  T_W  cycles, counted from entry into E, until the result is forwardable (jal/jalr/bgezal/bltzal link = 0, ALU/shift/lui/slt/movz = 1, lw/lb = 2)
- stall  output  1  freeze PC and F/D register; insert bubble into E
- fwd_d_rs  output  2  D-stage rs source: 0 regfile, 1 E, 2 M, 3 W
- fwd_d_rt  output  2  same for rt
- fwd_e_rs  output  2  E-stage rs source: 0 pipeline value, 2 M, 3 W
- fwd_e_rt  output  2  same for rt

Behaviour:
- State: three entries E, M, W. Each holds {valid, we, dst, tnew}. Entry E additionally holds {rs, rt}.
- Reset (synchronous): all valid = 0, we = 0, dst = 0, tnew = 0, E.rs = E.rt = 0. With all entries invalid, stall = 0 and all fwd = 0 in the same cycle reset is sampled high and afterwards.
- Capture rule: an entry is "writing" iff valid & we & dst != 0. d_dst = 0 is stored with we forced to 0, so $0 is never a hazard or forward source.
- Advance every clock when reset = 0:
  - W <= M, with tnew decremented and saturating at 0.
  - M <= E, with tnew decremented and saturating at 0.
  - If stall = 0: E <= {1, d_we, d_dst, d_tnew, d_rs, d_rt}.
  - If stall = 1: E <= bubble (valid = 0, we = 0, rs = rt = 0).
- D-stage match, per source s in {rs, rt} with tuse != TUSE_NONE and index != 0:
  - Search writing entries in priority E > M > W (youngest wins).
  - Only the first match is considered. An older entry never overrides a younger one.
- stall = 1 iff, for either source, the first match has tnew > tuse.
- fwd_d_s:
  - Stage code of the first match if its tnew == 0.
  - 0 if there is no match, the match has tnew != 0, or tuse == TUSE_NONE.
- E-stage forwarding, per E source (E.rs, E.rt; index != 0):
  - First match among writing M > W with tnew == 0 gives code 2 or 3.
  - Otherwise 0.
  - A matching M entry with tnew != 0 blocks W; select 0. This cannot occur legally, because D stalled earlier.
- All outputs are combinational from the current entries and D inputs. There are no output registers; latency is 0 cycles.
- Stall length:
  - Load in E, branch in D: stall 2 cycles.
  - Load in E, ALU in D: 1 cycle.
  - ALU in E, branch in D: 1 cycle.
  - Link writer in E: never stalls.
- Reset mid-stall: reset wins, all entries are cleared and stall drops the following evaluation.

Test Plan:
- ALU writer $3 (d_tnew 1) enters E; next D reads rs = $3, tuse 0 → stall = 1 for exactly 1 cycle. The following cycle stall = 0 and fwd_d_rs = 2.
- lw $5 (tnew 2) in E; D addu reads rt = $5, tuse 1 → stall 1 cycle. Then addu enters E with lw in W, tnew 0 → fwd_e_rt = 3, fwd_d_rt = 0.
- jal (dst 31, tnew 0) in E; D jr $31, tuse 0 → stall = 0, fwd_d_rs = 1.
- Writers of $7 in M (tnew 0) and W; D reads $7, tuse 1 → fwd = 2, not 3. Then replace the M writer with one to $0 → fwd = 3. A writer to $0 alone → fwd 0, stall 0.
- lw $4 in E; D beq $4 tuse 0 → stall held 2 cycles. Assert reset in the 2nd cycle → next cycle all entries invalid, stall = 0, all fwd = 0.
- D with tuse_rs = tuse_rt = 3 and rs = rt = $9 while a load of $9 is in E → stall = 0, fwd_d_rs = fwd_d_rt = 0.
